// File: rtl/ssram_pipe.sv
// Simple dual-port synchronous SRAM: byte-lane writes, 1- or 2-stage read pipeline, registered outputs.
// Optional power-up clear sweep enabled by defining SSRAM_PIPE_CLEAR_EN.
module ssram_pipe #(
  parameter int Depth     = 512,
  parameter int Width     = 8,
  parameter int ByteW     = 8,
  parameter int RdLatency = 1,
  parameter int RdwNew    = 0,
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int NB = Width / ByteW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [Width-1:0] WrData,
  input  logic [NB-1:0]    WrBe,
  input  logic             RdEn,
  input  logic [AW-1:0]    RdAddr,
  output logic [Width-1:0] RdData,
  output logic             RdValid,
  output logic             Busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(Depth);

  logic [Width-1:0] mem [0:Depth-1];

  logic             busy_s;
  logic             clr_we_s;
  logic [AW-1:0]    clr_addr_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             rd_in_range_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_addr_s;
  logic [Width-1:0] mem_wdata_s;
  logic [NB-1:0]    mem_be_s;
  logic [Width-1:0] rd_word_s;

  logic [RdLatency-1:0] pv_r;
  logic [Width-1:0]     pd_r [RdLatency];

  function automatic logic [Width-1:0] merge_lanes(
    input logic [Width-1:0] old_word,
    input logic [Width-1:0] new_word,
    input logic [NB-1:0]    be
  );
    logic [Width-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[i*ByteW +: ByteW] = new_word[i*ByteW +: ByteW];
      end else begin
        res[i*ByteW +: ByteW] = old_word[i*ByteW +: ByteW];
      end
    end
    return res;
  endfunction

`ifdef SSRAM_PIPE_CLEAR_EN
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(Depth - 1);

  state_t        state_r, state_nxt;
  logic [AW-1:0] clr_cnt_r, clr_cnt_nxt;

  // Sweep FSM state and counter register; reset always restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_cnt_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_nxt;
      clr_cnt_r <= clr_cnt_nxt;
    end
  end

  // Sweep FSM next-state: one zero word per CLEAR cycle, RUN after the last address.
  always_comb begin
    state_nxt   = state_r;
    clr_cnt_nxt = clr_cnt_r;
    clr_we_s    = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt   = RUN;
          clr_cnt_nxt = {AW{1'b0}};
        end else begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = clr_cnt_r + AW'(1);
        end
      end
      RUN: begin
        state_nxt   = RUN;
        clr_cnt_nxt = clr_cnt_r;
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = {AW{1'b0}};
      end
    endcase
  end

  assign busy_s     = (state_r == CLEAR);
  assign clr_addr_s = clr_cnt_r;
`else
  assign busy_s     = 1'b0;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = {AW{1'b0}};
`endif

  assign Busy = busy_s;

  // Request qualification: out-of-range writes vanish, out-of-range reads still return a (zero) result.
  always_comb begin
    wr_ok_s       = 1'b0;
    rd_ok_s       = 1'b0;
    rd_in_range_s = ({1'b0, RdAddr} < DEPTH_W);
    if (rst || busy_s) begin
      wr_ok_s = 1'b0;
      rd_ok_s = 1'b0;
    end else begin
      wr_ok_s = WrEn && ({1'b0, WrAddr} < DEPTH_W);
      rd_ok_s = RdEn;
    end
  end

  // Single write port shared between the clear sweep and user writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = WrAddr;
    mem_wdata_s = WrData;
    mem_be_s    = WrBe;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (clr_we_s) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = clr_addr_s;
      mem_wdata_s = {Width{1'b0}};
      mem_be_s    = {NB{1'b1}};
    end else begin
      mem_we_s = wr_ok_s;
    end
  end

  // Memory array update, lane by lane; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_s[i]) begin
          mem[mem_addr_s][i*ByteW +: ByteW] <= mem_wdata_s[i*ByteW +: ByteW];
        end
      end
    end
  end

  // Array read with same-address read-during-write resolution.
  always_comb begin
    rd_word_s = {Width{1'b0}};
    if (!rd_in_range_s) begin
      rd_word_s = {Width{1'b0}};
    end else if ((RdwNew != 0) && wr_ok_s && (WrAddr == RdAddr)) begin
      rd_word_s = merge_lanes(mem[RdAddr], WrData, WrBe);
    end else begin
      rd_word_s = mem[RdAddr];
    end
  end

  // Read pipeline valid bits; flushed by reset so in-flight reads never surface.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r <= {RdLatency{1'b0}};
    end else begin
      pv_r[0] <= rd_ok_s;
      for (int k = 1; k < RdLatency; k++) begin
        pv_r[k] <= pv_r[k-1];
      end
    end
  end

  // Read pipeline data; later stages are plain registers with no bypass.
  always_ff @(posedge clk) begin
    if (rd_ok_s) begin
      pd_r[0] <= rd_word_s;
    end
    for (int k = 1; k < RdLatency; k++) begin
      pd_r[k] <= pd_r[k-1];
    end
  end

  // Output register: data holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      RdValid <= 1'b0;
      RdData  <= {Width{1'b0}};
    end else begin
      RdValid <= pv_r[RdLatency-1];
      if (pv_r[RdLatency-1]) begin
        RdData <= pd_r[RdLatency-1];
      end
    end
  end

endmodule

// File: doc/ssram_pipe.md
SSRAM_PIPE -- requirements
Module: ssram_pipe

Interface
REQ-001 SHALL have parameter Depth, default 512: number of words; any value >= 2, not required to be a power of two.
REQ-002 SHALL have parameter Width, default 8: word width in bits; SHALL be an integer multiple of ByteW.
REQ-003 SHALL have parameter ByteW, default 8: bits per byte-enable lane; lanes NB = Width/ByteW.
REQ-004 SHALL have parameter RdLatency, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter RdwNew, default 0: same-address read-during-write result; 0 = old data, 1 = new data.
REQ-006 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port WrEn  input  1  write request.
REQ-009 SHALL have port WrAddr  input  AW=$clog2(Depth)  write address.
REQ-010 SHALL have port WrData  input  Width  write data.
REQ-011 SHALL have port WrBe  input  NB  byte-lane write enables; bit i covers WrData[i*ByteW +: ByteW].
REQ-012 SHALL have port RdEn  input  1  read request.
REQ-013 SHALL have port RdAddr  input  AW  read address.
REQ-014 SHALL have port RdData  output  Width  registered read data.
REQ-015 SHALL have port RdValid  output  1  RdData carries the result of a read this cycle.
REQ-016 SHALL have port Busy  output  1  clear sweep in progress; requests are ignored.

Function
REQ-017 A write SHALL occur on the edge where WrEn=1, Busy=0 and WrAddr<Depth; only lanes with WrBe[i]=1 SHALL be updated; WrBe=0 SHALL leave the word unchanged.
REQ-018 A write with WrAddr>=Depth SHALL be dropped with no side effect.
REQ-019 A read accepted on edge N (RdEn=1, Busy=0) SHALL present data and RdValid=1 after edge N+RdLatency-1+1; RdValid SHALL be high for exactly one cycle per accepted read.
REQ-020 Back-to-back reads SHALL sustain one result per cycle at either latency.
REQ-021 A read with RdAddr>=Depth SHALL return all zeros with RdValid=1 at the normal latency.
REQ-022 RdData SHALL hold its last value while RdValid=0.
REQ-023 For a read and write on the same edge at the same address: with RdwNew=0 the read SHALL return pre-write contents; with RdwNew=1 it SHALL return the merged word (written lanes new, unwritten lanes old).
REQ-024 For a read and write at different addresses on the same edge, both SHALL complete independently.
REQ-025 With RdLatency=2, the second stage SHALL be a plain pipeline register; no bypass is applied into stage 2.

Reset
REQ-026 While rst=1 at an edge: RdData SHALL be 0, RdValid SHALL be 0, the read pipeline SHALL be flushed, and no read or write SHALL occur.
REQ-027 Memory contents SHALL NOT be altered by rst itself, except through the REQ-029 sweep.
REQ-028 Reads in flight when rst is asserted SHALL be discarded and SHALL NOT produce RdValid.

Configuration
REQ-029 With macro SSRAM_PIPE_CLEAR_EN defined, an FSM with states CLEAR and RUN SHALL be implemented:
- rst enters CLEAR with the sweep counter at 0.
- Each CLEAR cycle writes all zeros to MEM[counter] and increments the counter.
- The FSM moves to RUN after address Depth-1 is written.
- Busy=1 for exactly Depth cycles after rst deasserts.
- WrEn and RdEn are ignored during CLEAR.
- rst asserted mid-sweep restarts the sweep at address 0.
REQ-030 Without SSRAM_PIPE_CLEAR_EN, Busy SHALL be constant 0, no sweep logic SHALL exist, memory SHALL be uninitialised, and requests SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-031 Byte lanes: Width=32, ByteW=8; write 0xAABBCCDD with WrBe=1111, then 0x11223344 with WrBe=0101, same address; read -> 0xAA22CC44.
REQ-032 Latency: RdLatency=2; reads of addresses 0,1,2 on three consecutive edges -> RdValid high on three consecutive cycles starting two cycles after the first request, with the data in order.
REQ-033 Read-during-write: address 5 holds 0x0F; same-edge write 0xF0 and read at address 5 -> 0x0F with RdwNew=0, 0xF0 with RdwNew=1.
REQ-034 Non-power-of-two: Depth=5; write 0x77 to address 6, then read address 6 -> 0x00; read address 0 -> unchanged.
REQ-035 Clear sweep: SSRAM_PIPE_CLEAR_EN defined, Depth=16; release rst -> Busy=1 for 16 cycles; a WrEn during Busy is ignored; read all addresses afterwards -> all 0. Reassert rst after 7 sweep cycles -> Busy restarts and lasts 16 cycles.
